// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu adder and its request scheduler: word layout,
// one-hot status encodings, scheduler state type and a status classifier.
package fpu_pkg;

    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int WORD_W = 32;

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_INEXACT   = 4'b0010;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
    localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    // Only clean one-hot OVERFLOW or UNDERFLOW codes count as errors; any
    // other pattern (including corrupt multi-hot codes) is not counted.
    function automatic logic is_err_status(input logic [3:0] st);
        return (st == ST_OVERFLOW) || (st == ST_UNDERFLOW);
    endfunction

endpackage

// File: rtl/fpu_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting one position past
// the last granted index and returns a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // Walk offsets 1..N from the last grant; the first active request wins.
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = PTR_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fpu_req_scheduler.sv
// Shares one fixed-latency fpu adder between N_REQ requesters. One operation
// is in flight at a time: arbitrate, issue operands, wait FPU_LAT clocks,
// capture the result, then hold it on the originator's response port.
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high. req_ready is a combinational one-hot grant offered only in IDLE;
// rsp_valid is held with stable data/status until the matching rsp_ready.
module fpu_req_scheduler
    import fpu_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int FPU_LAT = 2,
    parameter int ERR_W   = 8
) (
    input  logic                           clock100KHz,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][WORD_W-1:0]   req_op_a,
    input  logic [N_REQ-1:0][WORD_W-1:0]   req_op_b,
    output logic [N_REQ-1:0]               rsp_valid,
    input  logic [N_REQ-1:0]               rsp_ready,
    output logic [WORD_W-1:0]              rsp_data,
    output logic [3:0]                     rsp_status,
    output logic [WORD_W-1:0]              fpu_op_a,
    output logic [WORD_W-1:0]              fpu_op_b,
    input  logic [WORD_W-1:0]              fpu_data_in,
    input  logic [3:0]                     fpu_status_in,
    output logic                           busy,
    output logic [ERR_W-1:0]               err_count,
    output sched_state_t                   state_dbg
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

    sched_state_t      state_q, state_d;
    logic [PTR_W-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]  last_q, last_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [WORD_W-1:0] op_a_q, op_a_d;
    logic [WORD_W-1:0] op_b_q, op_b_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [3:0]        status_q, status_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Next-state and output decode for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        last_d    = last_q;
        lat_cnt_d = lat_cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        data_d    = data_q;
        status_d  = status_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;

        case (state_q)
            IDLE: begin
                req_ready = grant;
                // A grant always lands on a valid request, so any grant is a handshake.
                if (grant_any) begin
                    op_a_d    = req_op_a[grant_idx];
                    op_b_d    = req_op_b[grant_idx];
                    tag_d     = grant_idx;
                    last_d    = grant_idx;
                    lat_cnt_d = LAT_W'(FPU_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    data_d   = fpu_data_in;
                    status_d = fpu_status_in;
                    if (is_err_status(fpu_status_in) && (err_q != {ERR_W{1'b1}})) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                rsp_valid[tag_q] = 1'b1;
                if (rsp_ready[tag_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            last_q    <= PTR_W'(N_REQ - 1);
            lat_cnt_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            data_q    <= '0;
            status_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            last_q    <= last_d;
            lat_cnt_q <= lat_cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            data_q    <= data_d;
            status_q  <= status_d;
            err_q     <= err_d;
        end
    end

    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign rsp_data   = data_q;
    assign rsp_status = status_q;
    assign err_count  = err_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Directed bench for fpu_req_scheduler with an fpu stub whose data is
// op_a+op_b delayed to the sampling edge and whose status is set by the bench.
`timescale 1ns/1ps
module tb_fpu_req_scheduler;
    import fpu_pkg::*;

    localparam int N_REQ   = 2;
    localparam int FPU_LAT = 2;
    localparam int ERR_W   = 8;

    logic                         clk;
    logic                         rst_n;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][31:0]       req_op_a;
    logic [N_REQ-1:0][31:0]       req_op_b;
    logic [N_REQ-1:0]             rsp_valid;
    logic [N_REQ-1:0]             rsp_ready;
    logic [31:0]                  rsp_data;
    logic [3:0]                   rsp_status;
    logic [31:0]                  fpu_op_a;
    logic [31:0]                  fpu_op_b;
    logic [31:0]                  fpu_data_in;
    logic [3:0]                   fpu_status_in;
    logic                         busy;
    logic [ERR_W-1:0]             err_count;
    sched_state_t                 state_dbg;

    logic [31:0] stub_pipe;
    logic [3:0]  stub_status;

    int checks;
    int errors;

    fpu_req_scheduler #(
        .N_REQ   (N_REQ),
        .FPU_LAT (FPU_LAT),
        .ERR_W   (ERR_W)
    ) dut (
        .clock100KHz   (clk),
        .reset         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .fpu_op_a      (fpu_op_a),
        .fpu_op_b      (fpu_op_b),
        .fpu_data_in   (fpu_data_in),
        .fpu_status_in (fpu_status_in),
        .busy          (busy),
        .err_count     (err_count),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fpu stub: one register stage, so the sum is ready FPU_LAT=2 edges after issue
    always @(posedge clk) stub_pipe <= fpu_op_a + fpu_op_b;
    assign fpu_data_in   = stub_pipe;
    assign fpu_status_in = stub_status;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'h0);
        chk({tag, "_fpu_op_a"}, fpu_op_a, 32'h0);
        chk({tag, "_fpu_op_b"}, fpu_op_b, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_err"}, 32'(err_count), 32'h0);
        chk({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // Waits (bounded) at negedges until some rsp_valid bit is set.
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(rsp_valid != '0), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        logic seen;

        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        rsp_ready   = '0;
        req_op_a    = '0;
        req_op_b    = '0;
        stub_status = ST_EXACT;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single request from requester 0
        req_op_a[0] = 32'h0000_0003;
        req_op_b[0] = 32'h0000_0004;
        req_valid   = 2'b01;
        #1;
        chk("t1_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        chk("t1_wait_state", 32'(state_dbg), 32'(WAIT));
        chk("t1_busy_wait", 32'(busy), 32'h1);
        chk("t1_op_a", fpu_op_a, 32'h3);
        chk("t1_op_b", fpu_op_b, 32'h4);
        @(negedge clk);
        chk("t1_no_rsp_early", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data", rsp_data, 32'h7);
        chk("t1_rsp_status", 32'(rsp_status), 32'(ST_EXACT));
        chk("t1_busy_resp", 32'(busy), 32'h1);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        chk("t1_idle", 32'(state_dbg), 32'(IDLE));
        chk("t1_rsp_drop", 32'(rsp_valid), 32'h0);
        chk("t1_busy_idle", 32'(busy), 32'h0);

        // 2: both requesters valid from reset, alternate 0,1,0,1
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_op_a[0] = 32'd1;
        req_op_b[0] = 32'd1;
        req_op_a[1] = 32'd10;
        req_op_b[1] = 32'd20;
        req_valid   = 2'b11;
        for (int r = 0; r < 4; r++) begin
            #1;
            chk($sformatf("t2_grant_r%0d", r), 32'(req_ready), (r % 2 == 0) ? 32'h1 : 32'h2);
            wait_rsp($sformatf("t2_r%0d", r));
            chk($sformatf("t2_rsp_valid_r%0d", r), 32'(rsp_valid), (r % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("t2_rsp_data_r%0d", r), rsp_data, (r % 2 == 0) ? 32'd2 : 32'd30);
            rsp_ready = 2'b11;
            @(negedge clk);
            rsp_ready = '0;
        end

        // 3: response stalled 10 clocks, foreign rsp_ready ignored
        req_valid   = 2'b01;
        req_op_a[0] = 32'd5;
        req_op_b[0] = 32'd6;
        stub_status = ST_INEXACT;
        #1;
        chk("t3_grant", 32'(req_ready), 32'h1);
        wait_rsp("t3");
        req_valid = '0;
        rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_data_%0d", i), rsp_data, 32'd11);
            chk($sformatf("t3_status_%0d", i), 32'(rsp_status), 32'(ST_INEXACT));
            chk($sformatf("t3_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("t3_req_ready_%0d", i), 32'(req_ready), 32'h0);
            chk($sformatf("t3_op_a_%0d", i), fpu_op_a, 32'd5);
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        chk("t3_idle", 32'(state_dbg), 32'(IDLE));
        chk("t3_rsp_drop", 32'(rsp_valid), 32'h0);
        chk("t3_inexact_not_counted", 32'(err_count), 32'h0);

        // non-one-hot status passes through and is not counted
        req_valid   = 2'b01;
        req_op_a[0] = 32'd1;
        req_op_b[0] = 32'd1;
        stub_status = 4'b0110;
        #1;
        wait_rsp("t3b");
        req_valid = '0;
        chk("t3b_status_pass", 32'(rsp_status), 32'h6);
        chk("t3b_data", rsp_data, 32'd2);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        chk("t3b_not_counted", 32'(err_count), 32'h0);

        // 4: 300 OVERFLOW results saturate err_count
        stub_status = ST_OVERFLOW;
        req_op_a[0] = 32'd0;
        req_op_b[0] = 32'd0;
        req_valid   = 2'b01;
        rsp_ready   = 2'b01;
        n   = 0;
        cyc = 0;
        while (n < 300 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid[0]) begin
                n++;
                if (n == 10)  chk("t4_err_10", 32'(err_count), 32'd10);
                if (n == 254) chk("t4_err_254", 32'(err_count), 32'hFE);
                if (n == 255) chk("t4_err_255", 32'(err_count), 32'hFF);
                if (n == 256) chk("t4_err_sat", 32'(err_count), 32'hFF);
            end
        end
        req_valid = '0;
        chk("t4_rsp_count", 32'(n), 32'd300);
        chk("t4_err_final", 32'(err_count), 32'hFF);
        @(negedge clk);
        rsp_ready = '0;
        chk("t4_idle", 32'(state_dbg), 32'(IDLE));

        // 5: reset during WAIT
        stub_status = ST_EXACT;
        req_op_a[1] = 32'd7;
        req_op_b[1] = 32'd8;
        req_valid   = 2'b10;
        #1;
        chk("t5_grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        chk("t5_in_wait", 32'(state_dbg), 32'(WAIT));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | (rsp_valid != '0) | busy;
        end
        chk("t5_no_rsp_after", 32'(seen), 32'h0);
        req_op_a[0] = 32'd2;
        req_op_b[0] = 32'd3;
        req_valid   = 2'b11;
        #1;
        chk("t5_prio0", 32'(req_ready), 32'h1);
        wait_rsp("t5");
        req_valid = '0;
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t5_rsp_data", rsp_data, 32'd5);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;

        // 6: requester 1 pulses valid while requester 0 is in WAIT
        req_op_a[0] = 32'd100;
        req_op_b[0] = 32'd1;
        req_op_a[1] = 32'd9;
        req_op_b[1] = 32'd9;
        req_valid   = 2'b01;
        #1;
        chk("t6_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("t6_no_ready_in_wait", 32'(req_ready), 32'h0);
        @(negedge clk);
        req_valid = '0;
        wait_rsp("t6");
        chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t6_rsp_data", rsp_data, 32'd101);
        chk("t6_op_a_held", fpu_op_a, 32'd100);
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = '0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid[1] | busy;
        end
        chk("t6_req1_never_issued", 32'(seen), 32'h0);
        chk("t6_idle", 32'(state_dbg), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
